sc_mnist_readout: RTL



---
 rtl/sc_mnist_pkg.sv | 23 ++
 rtl/sc_bitstream_counter.sv | 36 +++
 rtl/sc_mnist_readout.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sc_mnist_pkg.sv
// rtl/sc_mnist_pkg.sv - shared state encoding and defaults for the SC MNIST readout
// The WARMUP state is only reachable when SC_READOUT_WARMUP_EN is defined.
package sc_mnist_pkg;

  localparam int N_CLASSES             = 10;
  localparam int WINDOW_LOG2_DEFAULT   = 8;
  localparam int WARMUP_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    SC_IDLE   = 3'd0,
    SC_WARMUP = 3'd1,
    SC_ACCUM  = 3'd2,
    SC_SCAN   = 3'd3,
    SC_DONE   = 3'd4
  } sc_state_e;

  localparam logic [2:0] ST_IDLE   = SC_IDLE;
  localparam logic [2:0] ST_WARMUP = SC_WARMUP;
  localparam logic [2:0] ST_ACCUM  = SC_ACCUM;
  localparam logic [2:0] ST_SCAN   = SC_SCAN;
  localparam logic [2:0] ST_DONE   = SC_DONE;

endpackage

// File: rtl/sc_bitstream_counter.sv
// rtl/sc_bitstream_counter.sv - ones counter for one class bitstream
// Clear has priority over enable; width is sized so a full window cannot overflow.
module sc_bitstream_counter
  import sc_mnist_pkg::*;
#(
  parameter int CW = WINDOW_LOG2_DEFAULT + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sc_mnist_readout.sv
// rtl/sc_mnist_readout.sv - windowed ones-count and argmax decoder for SC class bitstreams
// Define SC_READOUT_WARMUP_EN to discard the first W samples after start.
module sc_mnist_readout
  import sc_mnist_pkg::*;
#(
  parameter int N = N_CLASSES,
  parameter int L = WINDOW_LOG2_DEFAULT,
  parameter int W = WARMUP_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         din,
  output logic                 busy,
  output logic                 valid,
  output logic [$clog2(N)-1:0] class_idx,
  output logic [L:0]           max_count
);

  localparam int IW = $clog2(N);
  localparam int CW = L + 1;
  // The window counter doubles as the warm-up counter, so it must hold either span.
  localparam int WINW = (L > $clog2(W + 1)) ? L : $clog2(W + 1);
  localparam logic [WINW-1:0] WIN_LAST = WINW'((2 ** L) - 1);
`ifdef SC_READOUT_WARMUP_EN
  localparam logic [WINW-1:0] WARM_LAST = WINW'(W - 1);
`endif

  logic [2:0]      state_q, state_d;
  logic [WINW-1:0] win_q, win_d;
  logic [IW-1:0]   scan_q, scan_d;
  logic [CW-1:0]   best_cnt_q, best_cnt_d;
  logic [IW-1:0]   best_idx_q, best_idx_d;
  logic            valid_q, valid_d;
  logic [IW-1:0]   class_idx_q, class_idx_d;
  logic [CW-1:0]   max_count_q, max_count_d;

  logic            cnt_clr;
  logic [N-1:0]    cnt_en;
  logic [CW-1:0]   cnt [N];
  logic [CW-1:0]   sel_cnt;

  assign cnt_en = din & {N{state_q == ST_ACCUM}};

  for (genvar g = 0; g < N; g++) begin : g_cnt
    sc_bitstream_counter #(.CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .clr   (cnt_clr),
      .en    (cnt_en[g]),
      .count (cnt[g])
    );
  end

  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (scan_q == IW'(i)) sel_cnt = cnt[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    scan_d      = scan_q;
    best_cnt_d  = best_cnt_q;
    best_idx_d  = best_idx_q;
    valid_d     = 1'b0;
    class_idx_d = class_idx_q;
    max_count_d = max_count_q;
    cnt_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          win_d   = '0;
`ifdef SC_READOUT_WARMUP_EN
          state_d = ST_WARMUP;
`else
          state_d = ST_ACCUM;
`endif
        end
      end
`ifdef SC_READOUT_WARMUP_EN
      ST_WARMUP: begin
        if (win_q == WARM_LAST) begin
          win_d   = '0;
          state_d = ST_ACCUM;
        end else begin
          win_d = win_q + WINW'(1);
        end
      end
`endif
      ST_ACCUM: begin
        if (win_q == WIN_LAST) begin
          scan_d  = '0;
          state_d = ST_SCAN;
        end else begin
          win_d = win_q + WINW'(1);
        end
      end
      ST_SCAN: begin
        // Strict compare keeps the lowest index on ties; index 0 seeds the best.
        if (scan_q == '0 || sel_cnt > best_cnt_q) begin
          best_cnt_d = sel_cnt;
          best_idx_d = scan_q;
        end
        if (scan_q == IW'(N - 1)) begin
          state_d = ST_DONE;
        end else begin
          scan_d = scan_q + IW'(1);
        end
      end
      ST_DONE: begin
        valid_d     = 1'b1;
        class_idx_d = best_idx_q;
        max_count_d = best_cnt_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      win_q       <= '0;
      scan_q      <= '0;
      best_cnt_q  <= '0;
      best_idx_q  <= '0;
      valid_q     <= 1'b0;
      class_idx_q <= '0;
      max_count_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      scan_q      <= scan_d;
      best_cnt_q  <= best_cnt_d;
      best_idx_q  <= best_idx_d;
      valid_q     <= valid_d;
      class_idx_q <= class_idx_d;
      max_count_q <= max_count_d;
    end
  end

  // The result pulse is registered, so busy stays up through it.
  assign busy      = (state_q != ST_IDLE) | valid_q;
  assign valid     = valid_q;
  assign class_idx = class_idx_q;
  assign max_count = max_count_q;

endmodule
